// File: rtl/fifo_arb_pkg.sv
// Shared types and default constants for the FIFO write arbiter.
// Holds the throttle state enum and a wrap-around increment helper.
package fifo_arb_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } arb_state_e;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_CNT_W     = 4;
    localparam int DEF_N_REQ     = 2;
    localparam int DEF_HIGH_MARK = 6;
    localparam int DEF_LOW_MARK  = 2;

    function automatic int wrap_inc(input int i, input int n);
        return (i + 1 >= n) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set req at or after ptr.
// Output is one-hot, or zero when allow is low or nothing requests.
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    input  logic             allow,
    output logic [N_REQ-1:0] gnt
);

    logic found;
    int   idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        if (!allow) begin
            gnt = '0;
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares the FIFO write port between N_REQ producers and throttles
// writes with high/low watermark hysteresis on the FIFO occupancy.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int N_REQ     = DEF_N_REQ,
    parameter int HIGH_MARK = DEF_HIGH_MARK,
    parameter int LOW_MARK  = DEF_LOW_MARK
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] data,
    output logic [N_REQ-1:0]        gnt,
    input  logic [CNT_W-1:0]        fifo_words,
    input  logic                    full,
    output logic                    wr_en,
    output logic [DATA_W-1:0]       fifo_data,
    output logic                    paused
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [CNT_W:0]   HI = (CNT_W+1)'(HIGH_MARK);
    localparam logic [CNT_W-1:0] LO = CNT_W'(LOW_MARK);

    arb_state_e        state_q;
    arb_state_e        state_nx;
    logic [PTR_W-1:0]  ptr_q;
    logic [PTR_W-1:0]  ptr_nx;
    logic [CNT_W:0]    pending;
    logic [CNT_W:0]    pending_nx;
    logic              mark_ok;
    logic              allow;
    logic              any_gnt;
    logic [PTR_W-1:0]  gnt_idx;
    logic [DATA_W-1:0] sel_data;

    // The word registered last cycle is not yet in fifo_words.
    assign pending    = {1'b0, fifo_words} + {{CNT_W{1'b0}}, wr_en};
    assign pending_nx = pending + {{CNT_W{1'b0}}, any_gnt};

    always_comb begin
        mark_ok = 1'b0;
        unique case (state_q)
            FILL:    mark_ok = (pending < HI);
            DRAIN:   mark_ok = (fifo_words <= LO) && !wr_en;
            default: mark_ok = 1'b0;
        endcase
    end

    assign allow = mark_ok && !full && rst_n;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req   (req),
        .ptr   (ptr_q),
        .allow (allow),
        .gnt   (gnt)
    );

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                gnt_idx = PTR_W'(i);
            end
        end
    end

    assign any_gnt  = |gnt;
    assign sel_data = data[int'(gnt_idx)*DATA_W +: DATA_W];

    always_comb begin
        ptr_nx = ptr_q;
        if (any_gnt) begin
            ptr_nx = PTR_W'(wrap_inc(int'(gnt_idx), N_REQ));
        end
    end

    always_comb begin
        state_nx = state_q;
        unique case (state_q)
            FILL: begin
                if (pending_nx >= HI) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                // Resume in the same cycle the low mark is reached.
                if (allow) begin
                    state_nx = FILL;
                end
            end
            default: state_nx = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FILL;
            ptr_q     <= '0;
            wr_en     <= 1'b0;
            fifo_data <= '0;
        end else begin
            state_q <= state_nx;
            ptr_q   <= ptr_nx;
            wr_en   <= any_gnt;
            if (any_gnt) begin
                fifo_data <= sel_data;
            end
        end
    end

    assign paused = (state_q == DRAIN);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a behavioural 8-deep FIFO.
// Expected values are hand-derived cycle by cycle.
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req;
    logic [15:0] data;
    logic [1:0]  gnt;
    logic [3:0]  fifo_words;
    logic        full;
    logic        wr_en;
    logic [7:0]  fifo_data;
    logic        paused;

    logic        rd_en;
    logic        fifo_clr;
    logic        full_force;

    logic [7:0]  mem [8];
    logic [2:0]  wp;
    logic [2:0]  rp;
    logic [3:0]  cnt;
    logic [7:0]  rd_log [32];
    int          n_rd;
    logic [7:0]  n0;
    logic [7:0]  n1;
    logic        push;
    logic        pop;

    int n_checks;
    int n_errors;

    fifo_wr_arbiter #(
        .DATA_W    (8),
        .CNT_W     (4),
        .N_REQ     (2),
        .HIGH_MARK (6),
        .LOW_MARK  (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .data       (data),
        .gnt        (gnt),
        .fifo_words (fifo_words),
        .full       (full),
        .wr_en      (wr_en),
        .fifo_data  (fifo_data),
        .paused     (paused)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign data       = {8'h20 + n1, 8'h10 + n0};
    assign fifo_words = cnt;
    assign full       = (cnt == 4'd8) || full_force;
    assign push       = wr_en && (cnt != 4'd8);
    assign pop        = rd_en && (cnt != 4'd0);

    always @(posedge clk) begin
        if (fifo_clr) begin
            wp   <= '0;
            rp   <= '0;
            cnt  <= '0;
            n_rd <= 0;
            n0   <= '0;
            n1   <= '0;
        end else begin
            if (push) begin
                mem[wp] <= fifo_data;
                wp      <= wp + 3'd1;
            end
            if (pop) begin
                if (n_rd < 32) begin
                    rd_log[n_rd] <= mem[rp];
                    n_rd         <= n_rd + 1;
                end
                rp <= rp + 3'd1;
            end
            cnt <= cnt + 4'(push) - 4'(pop);
            if (gnt[0]) n0 <= n0 + 8'd1;
            if (gnt[1]) n1 <= n1 + 8'd1;
        end
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [1:0] r);
        rst_n      = 1'b0;
        fifo_clr   = 1'b1;
        full_force = 1'b0;
        rd_en      = 1'b0;
        req        = r;
        repeat (2) cyc();
    endtask

    logic [1:0] glog [8];
    logic [3:0] fwlog [16];
    logic       wrlog [16];
    int         ng;
    int         nw;
    int         first_w;
    int         last_w;
    int         n_bad;

    initial begin
        n_checks = 0;
        n_errors = 0;

        do_reset(2'b11);
        #1;
        check("rst_wr_en", wr_en, 0);
        check("rst_gnt", gnt, 0);
        check("rst_paused", paused, 0);

        // fill with both requesters
        cyc();
        rst_n    = 1'b1;
        fifo_clr = 1'b0;
        #1;
        ng = 0;
        nw = 0;
        for (int c = 0; c < 14; c++) begin
            if (gnt != 2'b00 && ng < 8) begin
                glog[ng] = gnt;
                ng++;
            end
            if (wr_en) nw++;
            cyc();
            #1;
        end
        check("fill_g0", glog[0], 2'b01);
        check("fill_g1", glog[1], 2'b10);
        check("fill_g2", glog[2], 2'b01);
        check("fill_g3", glog[3], 2'b10);
        check("fill_g4", glog[4], 2'b01);
        check("fill_g5", glog[5], 2'b10);
        check("fill_ngnt", ng, 6);
        check("fill_nwr", nw, 6);
        check("fill_words", fifo_words, 6);
        check("fill_paused", paused, 1);
        check("fill_nogGnt", gnt, 0);

        // drain with continuous reads, then resume
        rd_en = 1'b1;
        #1;
        for (int c = 0; c < 12; c++) begin
            fwlog[c] = fifo_words;
            wrlog[c] = wr_en;
            if (c == 4) check("drain_resume_gnt", gnt, 2'b01);
            if (c == 5) check("drain_resume_paused", paused, 0);
            cyc();
            #1;
        end
        rd_en = 1'b0;
        check("drain_fw1", fwlog[1], 5);
        check("drain_fw2", fwlog[2], 4);
        check("drain_fw3", fwlog[3], 3);
        check("drain_fw4", fwlog[4], 2);
        check("drain_wr4", wrlog[4], 0);
        check("drain_wr5", wrlog[5], 1);
        for (int c = 5; c < 10; c++) begin
            check($sformatf("hold_fw%0d", c), fwlog[c], 1);
        end
        check("rd0", rd_log[0], 8'h10);
        check("rd1", rd_log[1], 8'h20);
        check("rd2", rd_log[2], 8'h11);
        check("rd3", rd_log[3], 8'h21);
        check("rd4", rd_log[4], 8'h12);
        check("rd5", rd_log[5], 8'h22);
        check("rd6", rd_log[6], 8'h13);

        // single requester 1
        do_reset(2'b10);
        rst_n    = 1'b1;
        fifo_clr = 1'b0;
        #1;
        ng      = 0;
        nw      = 0;
        n_bad   = 0;
        first_w = -1;
        last_w  = -1;
        for (int c = 0; c < 14; c++) begin
            if (gnt != 2'b00) ng++;
            if (gnt != 2'b00 && gnt != 2'b10) n_bad++;
            if (wr_en) begin
                nw++;
                if (first_w < 0) first_w = c;
                last_w = c;
            end
            cyc();
            #1;
        end
        check("single_bad", n_bad, 0);
        check("single_ngnt", ng, 6);
        check("single_nwr", nw, 6);
        check("single_first", first_w, 1);
        check("single_last", last_w, 6);
        check("single_words", fifo_words, 6);
        check("single_paused", paused, 1);

        // full guard, then reset mid-fill
        do_reset(2'b11);
        rst_n      = 1'b1;
        fifo_clr   = 1'b0;
        full_force = 1'b1;
        #1;
        check("full_gnt", gnt, 0);
        cyc();
        full_force = 1'b0;
        #1;
        check("full_release_gnt", gnt, 2'b01);
        repeat (4) cyc();
        #1;
        check("mid_pre_wr", wr_en, 1);
        check("mid_pre_fw", fifo_words, 3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_gnt", gnt, 0);
        cyc();
        #1;
        check("mid_wr_en", wr_en, 0);
        check("mid_paused", paused, 0);
        rst_n = 1'b1;
        #1;
        check("mid_restart_gnt", gnt, 2'b01);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
